// File: rtl/dial_div_coprocessor.sv
// dial_div_coprocessor: tracks a dial position modulo DIAL_SIZE from signed
// rotation words and counts zero landings two ways. Count A counts rotations
// that end on zero; count B counts every click that passes onto zero. Each
// rotation is resolved by a fixed-latency restoring divider.
//
// Handshake: a word transfers on the rising edge where din_valid and
// din_ready are both high. din_ready is high only in IDLE with clear low.
// The sender holds din_valid and din until the transfer. dout_valid is a
// one-cycle pulse in the cycle the committed results first appear on dout.
module dial_div_coprocessor #(
   parameter int          WIDTH_DIN     = 128,
   parameter int          WIDTH_DOUT    = 128,
   parameter int          WIDTH_COMPUTE = 32,
   parameter int unsigned DIAL_SIZE     = 100,
   parameter int unsigned DIAL_START    = 50
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH_DIN-1:0]  din,
   input  logic                  din_valid,
   output logic                  din_ready,
   input  logic                  clear,
   input  logic [2:0]            sel,
   output logic [WIDTH_DOUT-1:0] dout,
   output logic                  dout_valid,
   output logic [7:0]            viz_position,
   output logic [7:0]            viz_count,
   output logic [1:0]            state_dbg
);

   localparam int W  = WIDTH_COMPUTE;
   localparam int CW = $clog2(W + 1);
   localparam logic [W:0]    N_EXT    = (W+1)'(DIAL_SIZE);
   localparam logic [W-1:0]  N_W      = W'(DIAL_SIZE);
   localparam logic [W-1:0]  START    = W'(DIAL_START);
   localparam logic [CW-1:0] LAST_BIT = CW'(W);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_DONE} state_t;

   state_t               state, state_nxt;
   logic [WIDTH_DIN-1:0] last_din;
   logic [W-1:0]         p, count_a, count_b, last_hits;
   logic [W:0]           qs;        // dividend shifting out, quotient shifting in
   logic [W-1:0]         rem;       // partial remainder, always < N
   logic [CW-1:0]        cnt;

   logic [W-1:0] r, m, b, rem_w, new_p;
   logic         r_neg, ge, accept;
   logic [W:0]   s, trial, rem_nxt;

   assign state_dbg = state;
   assign din_ready = (state == S_IDLE) && !clear;
   assign accept    = din_valid && din_ready;

   // Rotation decode: magnitude and the mirrored base for negative turns,
   // so both directions reduce to counting multiples of N in b + |r|.
   always_comb begin
      r     = last_din[W-1:0];
      r_neg = r[W-1];
      m     = r_neg ? (~r + W'(1)) : r;
      b     = r_neg ? ((p == '0) ? '0 : (N_W - p)) : p;
      s     = {1'b0, b} + {1'b0, m};
   end

   // One restoring-division step and the final position mapping.
   always_comb begin
      trial   = {rem, qs[W]};
      ge      = (trial >= N_EXT);
      rem_nxt = ge ? (trial - N_EXT) : trial;
      rem_w   = rem;
      new_p   = r_neg ? ((rem_w == '0) ? '0 : (N_W - rem_w)) : rem_w;
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic; clear aborts any operation back to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = S_LOAD;
         S_LOAD: state_nxt = S_DIV;
         S_DIV:  if (cnt == LAST_BIT) state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (clear) state_nxt = S_IDLE;
   end

   // Datapath: capture, divider iteration and result commit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_din   <= '0;
         p          <= START;
         count_a    <= '0;
         count_b    <= '0;
         last_hits  <= '0;
         qs         <= '0;
         rem        <= '0;
         cnt        <= '0;
         dout_valid <= 1'b0;
      end else if (clear) begin
         p          <= START;
         count_a    <= '0;
         count_b    <= '0;
         last_hits  <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         case (state)
            S_IDLE: if (accept) last_din <= din;
            S_LOAD: begin
               qs  <= s;
               rem <= '0;
               cnt <= '0;
            end
            S_DIV: begin
               qs  <= {qs[W-1:0], ge};
               rem <= rem_nxt[W-1:0];
               cnt <= cnt + CW'(1);
            end
            S_DONE: begin
               p          <= new_p;
               count_a    <= count_a + W'(new_p == '0);
               count_b    <= count_b + qs[W-1:0];
               last_hits  <= qs[W-1:0];
               dout_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Result select, zero-extended to the output width.
   always_comb begin
      dout = '0;
      case (sel)
         3'd0:    dout = WIDTH_DOUT'(last_din);
         3'd1:    dout = WIDTH_DOUT'(p);
         3'd2:    dout = WIDTH_DOUT'(count_a);
         3'd3:    dout = WIDTH_DOUT'(count_b);
         3'd4:    dout = WIDTH_DOUT'(last_hits);
         default: dout = WIDTH_DOUT'(count_b);
      endcase
   end

   assign viz_position = p[7:0];
   assign viz_count    = count_a[7:0];

endmodule

// File: doc/dial_div_coprocessor.md
# dial_div_coprocessor

Parametrised successor to the dial-rotation coprocessor: accepts signed rotation words from the UART front end, keeps the dial position modulo a configurable dial size, and maintains both puzzle answers at once. Count A is rotations ending on zero; count B is every click landing on zero. The iterative subtract-by-dial-size loop is replaced by a fixed-latency restoring divider, and a valid/ready handshake replaces the fire-and-forget input.

## Interface
- WIDTH_DIN, 128, input word width; the rotation is din[WIDTH_COMPUTE-1:0], two's complement.
- WIDTH_DOUT, 128, output word width.
- WIDTH_COMPUTE, 32, rotation, position and counter width (W).
- DIAL_SIZE, 100, modulus N. Legal range is 2 ≤ N ≤ 2^(W-1).
- DIAL_START, 50, position after reset or clear. Must be less than N.
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-low (0 = reset).
- din  in  WIDTH_DIN  rotation word.
- din_valid  in  1  rotation offered.
- din_ready  out  1  block idle and able to accept.
- clear  in  1  synchronous soft reset of dial state.
- sel  in  3  dout select.
- dout  out  WIDTH_DOUT  selected result, combinational from registers.
- dout_valid  out  1  one-cycle pulse when a rotation is committed.
- viz_position  out  8  position[7:0].
- viz_count  out  8  count_a[7:0].

## Operation
- States:
  - IDLE: din_ready=1.
  - LOAD: one cycle.
  - DIV: W+1 cycles.
  - DONE: one cycle.
- Accept occurs on the edge where din_valid & din_ready & !clear. On accept, capture the raw din into last_din and the rotation r, then go to LOAD.
- LOAD computes:
  - m = |r|, W bits unsigned. For r = -2^(W-1), m = 2^(W-1).
  - b = p if r ≥ 0. Otherwise b = (p==0 ? 0 : N-p), i.e. the mirrored position.
  - s = b + m, W+1 bits unsigned.
- DIV is a restoring division of s by N, one quotient bit per cycle, MSB first. The result is quotient q (W+1 bits) and remainder rem (less than N).
- DONE commits all of the following on one edge, then returns to IDLE and sets dout_valid:
  - p ← (r ≥ 0) ? rem : (rem==0 ? 0 : N-rem).
  - count_a ← count_a + (new p == 0).
  - count_b ← count_b + q[W-1:0].
  - last_hits ← q[W-1:0].
- r = 0 takes the normal path: q = 0, p is unchanged, and count_a increments only if p == 0.
- Counters wrap modulo 2^W. There is no saturation.
- sel decodes as follows; all values are zero-extended to WIDTH_DOUT:
  - 0: last_din.
  - 1: p.
  - 2: count_a.
  - 3: count_b.
  - 4: last_hits.
  - 5–7: count_b.
- clear, in any state:
  - p ← DIAL_START; count_a, count_b, last_hits ← 0.
  - Any operation in flight is aborted; next state is IDLE.
  - No dout_valid is produced.
  - din_ready is forced to 0 in the cycle clear is high, so clear beats a simultaneous din_valid.
- din_valid while busy (din_ready=0) is ignored and not queued. The sender must hold din_valid until accepted.

## Timing
- Reset values:
  - State IDLE, din_ready=1, dout_valid=0.
  - p=DIAL_START; count_a=count_b=last_hits=0; last_din=0.
  - viz_position=DIAL_START[7:0], viz_count=0.
  - dout as given by sel over these values.
- Reset assertion mid-operation aborts immediately, with no dout_valid.
- Latency: dout_valid goes high exactly W+3 cycles after the accept edge (35 for W=32) and stays high for one cycle.
- dout reflects the committed values in that same cycle.
- din_ready rises in the dout_valid cycle, so a new accept is possible on that cycle's edge. Maximum throughput is one rotation per W+3 cycles.
- din_ready is 0 from the cycle after accept until dout_valid.
- Critical path is one (W+1)-bit compare/subtract per cycle. No multiplier or divider primitive is used.

## Test plan
- Reset with N=100, start 50, then apply the rotation sequence −68, −30, +48, −5, +60, −55, −1, −99, +14, −82, each driven on din_valid&din_ready. Required: final p=32, count_a=3, count_b=6, ten dout_valid pulses each 35 cycles after its accept.
- From p=50 apply +1000. Required: last_hits=10, count_b=10, p=50, count_a=0.
- From p=50 apply −50, then 0. Required after −50: p=0, count_a=1, count_b=1. Required after 0: p=0, count_a=2, count_b=1, last_hits=0.
- From p=50 apply din[31:0]=0x80000000. Required: last_hits=21474836, p=2. Then from p=0 apply −5. Required: p=95, last_hits=0.
- Hold din_valid with a second word during the busy window. Required: din_ready=0 and no capture until the first dout_valid cycle; the second word is accepted on that edge.
- Assert clear in DIV, and separately assert clear together with din_valid in IDLE. Required: no dout_valid, p=50, counts 0, the word is not accepted. Finally pull rst low mid-DIV and check that all outputs hold their reset values.
